// File: rtl/posit_normalize_es3.sv
// -----------------------------------------------------------------------------
// posit_normalize_es3
// Three-stage posit packer for 32-bit, es=3 posits. Takes a serialized value
// {sgn, scale, fraction, inf, zero} and produces the encoded 32-bit posit word
// with round-to-nearest-even, maxpos/minpos saturation and sign application.
//
// Pipeline:
//   S1 decode      : clamp scale to [-240, 240], split into regime k and exponent e
//   S2 pack        : build regime/exponent/fraction string, extract body/guard/sticky
//   S3 round/sign  : RNE increment (never past maxpos), two's complement for sign
// All stages advance together on adv = ~out_valid | out_ready.
//
// Ports:
//   clk        in   1   clock, all state on rising edge
//   reset      in   1   asynchronous, active-high reset
//   in_valid   in   1   in_data valid
//   in_ready   out  1   block accepts in_data this cycle (combinational, = adv)
//   in_data    in   38  {sgn[37], scale[36:28], fraction[27:2], inf[1], zero[0]}
//   out_valid  out  1   out_posit valid
//   out_ready  in   1   consumer accepts out_posit
//   out_posit  out  32  encoded posit
// -----------------------------------------------------------------------------
module posit_normalize_es3 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [37:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_posit
);

    localparam int NBITS                      = 32;
    localparam int ES                         = 3;
    localparam int POSIT_SERIALIZED_WIDTH_ES3 = 38;

    localparam logic signed [8:0] SCALE_MAX_C = 9'sd240;
    localparam logic signed [8:0] SCALE_MIN_C = -9'sd240;
    localparam logic [30:0]       BODY_MAX_C  = 31'h7FFF_FFFF;

    // ------------------------------------------------------------------
    // Pipeline enable
    // ------------------------------------------------------------------
    logic adv_s;

    assign adv_s    = ~out_valid | out_ready;
    assign in_ready = adv_s;

    // ------------------------------------------------------------------
    // S1 decode (combinational front end)
    // ------------------------------------------------------------------
    logic signed [8:0] scale_s;
    logic signed [8:0] scale_clamp_s;
    logic        [5:0] k_s;
    logic        [2:0] e_s;

    assign scale_s = in_data[36:28];

    // Clamp scale so the regime never exceeds the word: results never round to 0 or inf.
    always_comb begin
        scale_clamp_s = scale_s;
        if (scale_s > SCALE_MAX_C) begin
            scale_clamp_s = SCALE_MAX_C;
        end else if (scale_s < SCALE_MIN_C) begin
            scale_clamp_s = SCALE_MIN_C;
        end else begin
            scale_clamp_s = scale_s;
        end
    end

    // k = scale >>> 3 is simply the top six bits of the clamped scale.
    assign k_s = scale_clamp_s[8:3];
    assign e_s = scale_clamp_s[2:0];

    logic        s1_valid_r;
    logic        s1_sgn_r;
    logic        s1_inf_r;
    logic        s1_zero_r;
    logic [5:0]  s1_k_r;
    logic [2:0]  s1_e_r;
    logic [25:0] s1_frac_r;

    // S1 valid bit: loads the handshake result whenever the pipe advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r <= in_valid;
        end
    end

    // S1 data: captured only for an accepted word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_sgn_r  <= 1'b0;
            s1_inf_r  <= 1'b0;
            s1_zero_r <= 1'b0;
            s1_k_r    <= 6'd0;
            s1_e_r    <= 3'd0;
            s1_frac_r <= 26'd0;
        end else if (adv_s && in_valid) begin
            s1_sgn_r  <= in_data[37];
            s1_inf_r  <= in_data[1];
            s1_zero_r <= in_data[0];
            s1_k_r    <= k_s;
            s1_e_r    <= e_s;
            s1_frac_r <= in_data[27:2];
        end
    end

    // ------------------------------------------------------------------
    // S2 pack
    // ------------------------------------------------------------------
    // The regime run is produced by sign-extending a seed:
    //   k >= 0 : seed 10.e.f shifted right by k      -> k+1 ones, then 0
    //   k <  0 : seed 01.e.f shifted right by -k-1   -> -k zeros, then 1
    // -k-1 equals ~k in two's complement. The 64-bit field keeps every shifted
    // bit, so truncated regime/exponent/fraction bits land in guard/sticky.
    logic signed [63:0] seed_s;
    logic        [5:0]  shamt_s;
    logic        [63:0] shifted_s;
    logic        [30:0] body_s;
    logic               guard_s;
    logic               sticky_s;

    // Select seed pattern and shift distance by regime sign.
    always_comb begin
        seed_s  = 64'sd0;
        shamt_s = 6'd0;
        if (s1_k_r[5] == 1'b0) begin
            seed_s  = {2'b10, s1_e_r, s1_frac_r, 33'd0};
            shamt_s = s1_k_r;
        end else begin
            seed_s  = {2'b01, s1_e_r, s1_frac_r, 33'd0};
            shamt_s = ~s1_k_r;
        end
    end

    assign shifted_s = seed_s >>> shamt_s;
    assign body_s    = shifted_s[63:33];
    assign guard_s   = shifted_s[32];
    assign sticky_s  = |shifted_s[31:0];

    logic        s2_valid_r;
    logic        s2_sgn_r;
    logic        s2_inf_r;
    logic        s2_zero_r;
    logic [30:0] s2_body_r;
    logic        s2_guard_r;
    logic        s2_sticky_r;

    // S2 valid bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r;
        end
    end

    // S2 data: packed body plus rounding information.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_sgn_r    <= 1'b0;
            s2_inf_r    <= 1'b0;
            s2_zero_r   <= 1'b0;
            s2_body_r   <= 31'd0;
            s2_guard_r  <= 1'b0;
            s2_sticky_r <= 1'b0;
        end else if (adv_s && s1_valid_r) begin
            s2_sgn_r    <= s1_sgn_r;
            s2_inf_r    <= s1_inf_r;
            s2_zero_r   <= s1_zero_r;
            s2_body_r   <= body_s;
            s2_guard_r  <= guard_s;
            s2_sticky_r <= sticky_s;
        end
    end

    // ------------------------------------------------------------------
    // S3 round and sign
    // ------------------------------------------------------------------
    logic        round_up_s;
    logic [30:0] body_rnd_s;
    logic [31:0] mag_s;
    logic [31:0] result_s;

    // maxpos never increments, so the rounded body cannot carry into the sign bit.
    assign round_up_s = s2_guard_r & (s2_body_r[0] | s2_sticky_r) & (s2_body_r != BODY_MAX_C);
    assign body_rnd_s = s2_body_r + {30'd0, round_up_s};
    assign mag_s      = {1'b0, body_rnd_s};

    // Special values override the packed magnitude; inf wins over zero.
    always_comb begin
        result_s = 32'd0;
        if (s2_inf_r) begin
            result_s = 32'h8000_0000;
        end else if (s2_zero_r) begin
            result_s = 32'h0000_0000;
        end else if (s2_sgn_r) begin
            result_s = ~mag_s + 32'd1;
        end else begin
            result_s = mag_s;
        end
    end

    // S3 valid bit drives out_valid directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (adv_s) begin
            out_valid <= s2_valid_r;
        end
    end

    // S3 data: output word, held through stalls and bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_posit <= 32'd0;
        end else if (adv_s && s2_valid_r) begin
            out_posit <= result_s;
        end
    end

endmodule
